ascon_decrypt: RTL and testbench
================================

# ascon_decrypt

Sequential ASCON-128 authenticated-decryption engine. It is the receive-side counterpart of the encryption datapath `permutation_xor`. It reuses the existing `constant_addition`, `substitution_layer` and `diffusion_layer` cells at one round per clock, sequenced by an internal FSM and round counter. It takes a key, nonce, one associated-data block, a 128-bit tag and a stream of ciphertext blocks. It returns plaintext blocks and a tag-verification verdict.

## Interface
- `NB_BLOCKS`, default 3: number of 64-bit ciphertext blocks per message (≥1). The padding is already contained in the last block.
- `clock_i` in 1: single clock, rising edge.
- `resetb_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request, sampled only in IDLE.
- `key_i` in 128: key K, latched at start.
- `nonce_i` in 128: nonce N, latched at start.
- `ad_i` in 64: associated-data block A (padded), latched at start.
- `tag_i` in 128: received tag, latched at start.
- `cipher_i` in 64: ciphertext block.
- `cipher_valid_i` in 1: `cipher_i` valid.
- `cipher_ready_o` out 1: engine accepts a ciphertext block.
- `plain_o` out 64: plaintext block, registered.
- `plain_valid_o` out 1: one-cycle pulse, `plain_o` is new.
- `tag_o` out 128: computed tag (see Configuration).
- `auth_ok_o` out 1: computed tag equals latched `tag_i`. Held until the next start.
- `busy_o` out 1: engine not in IDLE.
- `done_o` out 1: one-cycle pulse, message complete and `auth_ok_o` valid.

## Operation
- State S = S0..S4, 64 bits each. IV = 0x80400C0600000000.
- FSM states and transitions:
  - IDLE: on `start_i`, load S = IV‖K‖N, latch K/A/tag, block counter = 0, go to INIT.
  - INIT: 12 rounds, constants 0..11. The last round writes p(S) ⊕ (0¹⁹²‖K).
  - ASSOC: 6 rounds, constants 6..11. The first round is applied to S with S0 ⊕ A. The last round writes p(S) ⊕ (0³¹⁹‖1).
  - WAIT_C: `cipher_ready_o` = 1. On a transfer (valid & ready), `plain_o` ← S0 ⊕ C, then S0 ← C.
    - If this is not the last block: increment the block counter and go to PROC_C.
    - If it is the last block: go to FINAL.
  - PROC_C: 6 rounds, constants 6..11, then return to WAIT_C.
  - FINAL: 12 rounds, constants 0..11. The first round is applied to S ⊕ (0⁶⁴‖K‖0¹²⁸).
    - Last round: T = (S3‖S4 of the round output) ⊕ K.
    - Register `auth_ok_o` ← (T == latched tag). Go to DONE.
  - DONE: `done_o` = 1 for one cycle, then IDLE.
- Round counter is 4 bits and reloads on each phase entry; no wrap beyond 11.
- Tag comparison is a full 128-bit equality, evaluated once. `auth_ok_o` = 0 on any mismatch.
- Plaintext is streamed before verification. The consumer must discard it when `done_o` comes with `auth_ok_o` = 0.

## Timing
- Reset, asynchronous and immediate: FSM goes to IDLE and every output is 0 (`plain_o`, `tag_o`, `auth_ok_o`, `busy_o`, `done_o`, `cipher_ready_o`, `plain_valid_o`).
- Reset mid-message aborts silently; no `done_o`.
- Edge-by-edge schedule, with `start_i` sampled at edge E0:
  - INIT on E1..E12, ASSOC on E13..E18.
  - `cipher_ready_o` first high after E18.
  - Each non-last block costs one transfer edge plus 6 round edges.
- Latency with `cipher_valid_i` held high:
  - Last transfer at E(19+7·(NB_BLOCKS−1)).
  - FINAL occupies the 12 following edges.
  - `done_o` is high in the cycle after the last FINAL edge: 46 cycles after E0 for NB_BLOCKS = 3.
- `plain_valid_o` pulses in the cycle after each transfer.
- `cipher_valid_i` may stall indefinitely; the engine waits in WAIT_C.
- `cipher_ready_o` is 0 in every other state, and blocks offered then are not consumed.
- `start_i` while `busy_o` = 1 is ignored.
- `auth_ok_o` clears on the edge that accepts a new start.

## Configuration
- `ASCON_TAG_OUT_EN` defined: `tag_o` is a 128-bit register loaded with T on the last FINAL edge and held until the next start.
- `ASCON_TAG_OUT_EN` undefined: `tag_o` is tied to 0 and no register is built; only `auth_ok_o` reveals the verification result.

## Test plan
- Round trip: K = N = 0x000102…0F, A = 0x0123456789ABCDEF, 3 plaintext blocks encrypted by the team golden model, valid held high.
  - `plain_o` must match P1..P3 in order.
  - `auth_ok_o` = 1 with `done_o` exactly 46 cycles after start.
- Tag corruption: same vector with `tag_i` bit 0 flipped.
  - Plaintext is unchanged.
  - `done_o` at 46 cycles with `auth_ok_o` = 0.
  - With the macro defined, `tag_o` equals the golden tag.
- Ciphertext stall: drop `cipher_valid_i` for 10 cycles before block 2.
  - `cipher_ready_o` stays high throughout the stall.
  - `done_o` arrives at 56 cycles with `auth_ok_o` = 1.
- Reset abort: assert `resetb_i` = 0 during FINAL.
  - All outputs are 0 immediately.
  - A following clean start reproduces the first scenario's result.
- Busy start: pulse `start_i` during PROC_C.
  - No effect; the result is identical to the first scenario.
  - Then NB_BLOCKS = 1 (parameter override) with a single-block golden vector: `done_o` at 32 cycles, `auth_ok_o` = 1.

Source files
------------

// File: rtl/ascon_decrypt.sv
// ASCON-128 authenticated decryption engine, one permutation round per clock.
// Define ASCON_TAG_OUT_EN to register the computed tag onto tag_o.
module ascon_decrypt #(
    parameter int NB_BLOCKS = 3
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    output logic         cipher_ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic [127:0] tag_o,
    output logic         auth_ok_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam logic [63:0] IV = 64'h80400C0600000000;
    localparam int BW = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NB_BLOCKS - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, ASSOC, WAIT_C, PROC_C, FINAL, DONE
    } state_t;

    state_t state_q;
    logic [3:0] rnd_q;
    logic [BW-1:0] blk_q;
    logic [4:0][63:0] s_q;
    logic [4:0][63:0] s_in;
    logic [4:0][63:0] s_d;
    logic [127:0] key_q;
    logic [127:0] tag_q;
    logic [63:0] ad_q;
    logic [63:0] plain_q;
    logic plain_valid_q;
    logic auth_ok_q;
    logic done_q;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] y0, y1, y2, y3, y4;
    logic [63:0] z0, z1, z2, z3, z4;
    logic [127:0] t_calc;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Phase-entry injections (A at ASSOC start, K at FINAL start) feed the round.
    always_comb begin
        s_in = s_q;
        if (state_q == ASSOC && rnd_q == 4'd6) begin
            s_in[0] = s_q[0] ^ ad_q;
        end
        if (state_q == FINAL && rnd_q == 4'd0) begin
            s_in[1] = s_q[1] ^ key_q[127:64];
            s_in[2] = s_q[2] ^ key_q[63:0];
        end
        a0 = s_in[0] ^ s_in[4];
        a1 = s_in[1];
        a2 = s_in[2] ^ {56'd0, 4'hF - rnd_q, rnd_q} ^ s_in[1];
        a3 = s_in[3];
        a4 = s_in[4] ^ s_in[3];
        y0 = a0 ^ (~a1 & a2);
        y1 = a1 ^ (~a2 & a3);
        y2 = a2 ^ (~a3 & a4);
        y3 = a3 ^ (~a4 & a0);
        y4 = a4 ^ (~a0 & a1);
        z1 = y1 ^ y0;
        z0 = y0 ^ y4;
        z3 = y3 ^ y2;
        z2 = ~y2;
        z4 = y4;
        s_d[0] = z0 ^ ror(z0, 19) ^ ror(z0, 28);
        s_d[1] = z1 ^ ror(z1, 61) ^ ror(z1, 39);
        s_d[2] = z2 ^ ror(z2, 1) ^ ror(z2, 6);
        s_d[3] = z3 ^ ror(z3, 10) ^ ror(z3, 17);
        s_d[4] = z4 ^ ror(z4, 7) ^ ror(z4, 41);
        t_calc = {s_d[3], s_d[4]} ^ key_q;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= IDLE;
            rnd_q         <= '0;
            blk_q         <= '0;
            s_q           <= '0;
            key_q         <= '0;
            tag_q         <= '0;
            ad_q          <= '0;
            plain_q       <= '0;
            plain_valid_q <= 1'b0;
            auth_ok_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            plain_valid_q <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                IDLE: if (start_i) begin
                    s_q <= {nonce_i[63:0], nonce_i[127:64],
                            key_i[63:0], key_i[127:64], IV};
                    key_q     <= key_i;
                    ad_q      <= ad_i;
                    tag_q     <= tag_i;
                    blk_q     <= '0;
                    rnd_q     <= 4'd0;
                    auth_ok_q <= 1'b0;
                    state_q   <= INIT;
                end
                INIT: begin
                    s_q <= s_d;
                    if (rnd_q == 4'd11) begin
                        s_q[3]  <= s_d[3] ^ key_q[127:64];
                        s_q[4]  <= s_d[4] ^ key_q[63:0];
                        rnd_q   <= 4'd6;
                        state_q <= ASSOC;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ASSOC: begin
                    s_q <= s_d;
                    if (rnd_q == 4'd11) begin
                        s_q[4]  <= s_d[4] ^ 64'd1;
                        state_q <= WAIT_C;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                WAIT_C: if (cipher_valid_i) begin
                    plain_q       <= s_q[0] ^ cipher_i;
                    plain_valid_q <= 1'b1;
                    s_q[0]        <= cipher_i;
                    if (blk_q == LAST) begin
                        rnd_q   <= 4'd0;
                        state_q <= FINAL;
                    end else begin
                        blk_q   <= blk_q + 1'b1;
                        rnd_q   <= 4'd6;
                        state_q <= PROC_C;
                    end
                end
                PROC_C: begin
                    s_q <= s_d;
                    if (rnd_q == 4'd11) begin
                        state_q <= WAIT_C;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                FINAL: begin
                    s_q <= s_d;
                    if (rnd_q == 4'd11) begin
                        auth_ok_q <= (t_calc == tag_q);
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ASCON_TAG_OUT_EN
    logic [127:0] tag_out_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            tag_out_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            tag_out_q <= '0;
        end else if (state_q == FINAL && rnd_q == 4'd11) begin
            tag_out_q <= t_calc;
        end
    end

    assign tag_o = tag_out_q;
`else
    assign tag_o = '0;
`endif

    assign cipher_ready_o = (state_q == WAIT_C);
    assign busy_o         = (state_q != IDLE);
    assign plain_o        = plain_q;
    assign plain_valid_o  = plain_valid_q;
    assign auth_ok_o      = auth_ok_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_ascon_decrypt.sv
// Scoreboard bench for ascon_decrypt: an encrypting reference model builds
// ciphertext and tag from directed plaintext; a monitor checks every output.
module tb_ascon_decrypt;
    logic clk;
    logic rst_n;
    logic start0, start1;
    logic [127:0] key, nonce, tag_in;
    logic [63:0] ad, cipher;
    logic valid;

    logic rdy0, pv0, auth0, busy0, done0;
    logic [63:0] plain0;
    logic [127:0] tago0;
    logic rdy1, pv1, auth1, busy1, done1;
    logic [63:0] plain1;
    logic [127:0] tago1;

    typedef struct {
        logic auth;
        int lat;
        logic [127:0] tag;
    } res_t;

    logic [63:0] q0p[$];
    logic [63:0] q1p[$];
    res_t q0r[$];
    res_t q1r[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0_0 = 0;
    int t0_1 = 0;

    logic [63:0] pt[3];
    logic [63:0] ct[3];
    logic [127:0] gtag;
    logic [63:0] m[5];
    logic [4:0] sbox[32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    ascon_decrypt #(.NB_BLOCKS(3)) dut (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start0),
        .key_i(key), .nonce_i(nonce), .ad_i(ad), .tag_i(tag_in),
        .cipher_i(cipher), .cipher_valid_i(valid),
        .cipher_ready_o(rdy0), .plain_o(plain0), .plain_valid_o(pv0),
        .tag_o(tago0), .auth_ok_o(auth0), .busy_o(busy0), .done_o(done0)
    );

    ascon_decrypt #(.NB_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start1),
        .key_i(key), .nonce_i(nonce), .ad_i(ad), .tag_i(tag_in),
        .cipher_i(cipher), .cipher_valid_i(valid),
        .cipher_ready_o(rdy1), .plain_o(plain1), .plain_valid_o(pv1),
        .tag_o(tago1), .auth_ok_o(auth1), .busy_o(busy1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    // Reference permutation: S-box applied by table lookup per bit column.
    task automatic perm(input int first);
        logic [63:0] t[5];
        logic [4:0] v, o;
        for (int r = first; r < 12; r++) begin
            m[2] = m[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                v = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
                o = sbox[v];
                t[0][b] = o[4];
                t[1][b] = o[3];
                t[2][b] = o[2];
                t[3][b] = o[1];
                t[4][b] = o[0];
            end
            m[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
            m[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
            m[2] = t[2] ^ rr(t[2], 1) ^ rr(t[2], 6);
            m[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
            m[4] = t[4] ^ rr(t[4], 7) ^ rr(t[4], 41);
        end
    endtask

    task automatic encrypt(input int nb);
        m[0] = 64'h80400C0600000000;
        m[1] = key[127:64];
        m[2] = key[63:0];
        m[3] = nonce[127:64];
        m[4] = nonce[63:0];
        perm(0);
        m[3] = m[3] ^ key[127:64];
        m[4] = m[4] ^ key[63:0];
        m[0] = m[0] ^ ad;
        perm(6);
        m[4] = m[4] ^ 64'd1;
        for (int i = 0; i < nb; i++) begin
            ct[i] = m[0] ^ pt[i];
            m[0] = ct[i];
            if (i < nb - 1) perm(6);
        end
        m[1] = m[1] ^ key[127:64];
        m[2] = m[2] ^ key[63:0];
        perm(0);
        gtag = {m[3], m[4]} ^ key;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pv0) begin
                if (q0p.size() == 0) chk("unexpected plain0", 128'(plain0), 128'd0 - 1);
                else chk("plain0", 128'(plain0), 128'(q0p.pop_front()));
            end
            if (done0) begin
                res_t r;
                if (q0r.size() == 0) begin
                    chk("unexpected done0", 128'(done0), 128'd0);
                end else begin
                    r = q0r.pop_front();
                    chk("auth0", 128'(auth0), 128'(r.auth));
                    chk("latency0", 128'(cyc - t0_0 + 1), 128'(r.lat));
                    chk("tag0", tago0, r.tag);
                end
            end
            if (pv1) begin
                if (q1p.size() == 0) chk("unexpected plain1", 128'(plain1), 128'd0 - 1);
                else chk("plain1", 128'(plain1), 128'(q1p.pop_front()));
            end
            if (done1) begin
                res_t r;
                if (q1r.size() == 0) begin
                    chk("unexpected done1", 128'(done1), 128'd0);
                end else begin
                    r = q1r.pop_front();
                    chk("auth1", 128'(auth1), 128'(r.auth));
                    chk("latency1", 128'(cyc - t0_1 + 1), 128'(r.lat));
                    chk("tag1", tago1, r.tag);
                end
            end
        end
    end

    function automatic logic rdy_of(input bit sel);
        return sel ? rdy1 : rdy0;
    endfunction

    task automatic wait_ready(input bit sel);
        int n;
        n = 0;
        while (!rdy_of(sel) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("ready timeout", 128'(rdy_of(sel)), 128'd1);
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while (!(sel ? done1 : done0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("done timeout", 128'(sel ? done1 : done0), 128'd1);
    endtask

    task automatic check_zero();
        chk("rst plain_o", 128'(plain0), 128'd0);
        chk("rst tag_o", tago0, 128'd0);
        chk("rst auth_ok_o", 128'(auth0), 128'd0);
        chk("rst busy_o", 128'(busy0), 128'd0);
        chk("rst done_o", 128'(done0), 128'd0);
        chk("rst cipher_ready_o", 128'(rdy0), 128'd0);
        chk("rst plain_valid_o", 128'(pv0), 128'd0);
    endtask

    task automatic send(input bit sel, input int nb, input int stall_at,
                        input bit busy);
        for (int i = 0; i < nb; i++) begin
            cipher = ct[i];
            if (i == stall_at) begin
                valid = 1'b0;
                wait_ready(sel);
                for (int k = 0; k < 10; k++) begin
                    chk("stall ready", 128'(rdy_of(sel)), 128'd1);
                    @(negedge clk);
                end
            end
            valid = 1'b1;
            wait_ready(sel);
            @(posedge clk);
            #1;
            if (busy && i == 0) begin
                @(negedge clk);
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
            end
        end
        valid = 1'b0;
    endtask

    task automatic run(input bit sel, input int nb, input int stall_at,
                       input bit flip, input int lat, input bit abort,
                       input bit busy);
        res_t r;
        @(negedge clk);
        tag_in = flip ? (gtag ^ 128'd1) : gtag;
        r.auth = !flip;
        r.lat = lat;
`ifdef ASCON_TAG_OUT_EN
        r.tag = gtag;
`else
        r.tag = 128'd0;
`endif
        for (int i = 0; i < nb; i++) begin
            if (sel) q1p.push_back(pt[i]);
            else q0p.push_back(pt[i]);
        end
        if (!abort) begin
            if (sel) q1r.push_back(r);
            else q0r.push_back(r);
        end
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (sel) t0_1 = cyc;
        else t0_0 = cyc;
        send(sel, nb, stall_at, busy);
        if (abort) begin
            repeat (5) @(negedge clk);
            chk("busy in FINAL", 128'(busy0), 128'd1);
            #2 rst_n = 1'b0;
            #1 check_zero();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            wait_done(sel);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        valid = 1'b0;
        cipher = '0;
        tag_in = '0;
        key = 128'h000102030405060708090A0B0C0D0E0F;
        nonce = 128'h000102030405060708090A0B0C0D0E0F;
        ad = 64'h0123456789ABCDEF;
        #2 check_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pt[0] = 64'h5468652071756963;
        pt[1] = 64'h6B2062726F776E20;
        pt[2] = 64'h666F788000000000;
        encrypt(3);
        run(0, 3, -1, 0, 46, 0, 0);
        run(0, 3, -1, 1, 46, 0, 0);
        run(0, 3, 1, 0, 56, 0, 0);
        run(0, 3, -1, 0, 46, 1, 0);
        run(0, 3, -1, 0, 46, 0, 0);
        run(0, 3, -1, 0, 46, 0, 1);

        pt[0] = 64'h4173636F6E800000;
        encrypt(1);
        run(1, 1, -1, 0, 32, 0, 0);

        repeat (4) @(negedge clk);
        chk("q0 plain drained", 128'(q0p.size()), 128'd0);
        chk("q0 result drained", 128'(q0r.size()), 128'd0);
        chk("q1 plain drained", 128'(q1p.size()), 128'd0);
        chk("q1 result drained", 128'(q1r.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
